aes256_req_arbiter: RTL and testbench

Shares one aes256_core between NUM_REQ independent requesters. Arbitrates round-robin, latches the winner's mode, block and key, and holds them stable on the core inputs for the whole operation, because the core's key expansion and mode select are combinational. Pulses the core start, waits for the core valid, and returns the result to the granted requester over a valid/ready response channel. Sits directly above aes256_core in the crypto subsystem.

---
 rtl/aes256_req_arbiter.sv | 159 +++++++++++++++
 tb/tb_aes256_req_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes256_req_arbiter.sv
// aes256_req_arbiter
// Shares one aes256_core between NUM_REQ requesters. Round-robin grant in
// IDLE, latch the winner's mode/block/key, hold them on the core inputs for
// the whole job, pulse start, wait for the core's valid (or time out), then
// return the result over the winner's response channel.
//
// Ports
//   clk, rst_n              clock, async active-low reset
//   req_valid_i/ready_o     per-requester job handshake (ready one-hot or 0)
//   req_mode_i              per-requester mode, 0=encrypt 1=decrypt
//   req_data_i/key_i        packed blocks (128b each) and keys (256b each)
//   rsp_valid_o/ready_i     per-requester response handshake
//   rsp_data_o, rsp_err_o   shared result block, timeout flag (data is 0)
//   grant_idx_o             current or last granted requester
//   core_*_o                start pulse and latched mode/block/key to core
//   core_result_i/valid_i   core output
//   core_busy_i             core busy; start is held off while set
module aes256_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int IDX_W          = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ-1:0]       req_mode_i,
  input  logic [NUM_REQ*128-1:0]   req_data_i,
  input  logic [NUM_REQ*256-1:0]   req_key_i,
  output logic [NUM_REQ-1:0]       rsp_valid_o,
  input  logic [NUM_REQ-1:0]       rsp_ready_i,
  output logic [127:0]             rsp_data_o,
  output logic                     rsp_err_o,
  output logic [IDX_W-1:0]         grant_idx_o,
  output logic                     core_start_o,
  output logic                     core_mode_o,
  output logic [127:0]             core_data_o,
  output logic [255:0]             core_key_o,
  input  logic [127:0]             core_result_i,
  input  logic                     core_valid_i,
  input  logic                     core_busy_i
);

  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                    state, state_nxt;
  logic [NUM_REQ-1:0][127:0] req_data_v;
  logic [NUM_REQ-1:0][255:0] req_key_v;
  logic [IDX_W-1:0]          last, gnt_idx, pick, cand;
  logic                      pick_vld, accept;
  logic [TMO_W-1:0]          tmo_cnt;
  logic                      tmo_hit;
  logic [127:0]              result;
  logic                      err;
  logic                      mode_q;
  logic [127:0]              data_q;
  logic [255:0]              key_q;

  assign req_data_v = req_data_i;
  assign req_key_v  = req_key_i;

  // Round-robin search starting just after the last served requester.
  // Walk from the far end so the nearest valid index is the one left in pick.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last) + k) % NUM_REQ);
      if (req_valid_i[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  assign tmo_hit = (tmo_cnt == TMO_LAST);

  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    core_start_o = 1'b0;
    case (state)
      IDLE:  if (pick_vld) begin
               accept    = 1'b1;
               state_nxt = ISSUE;
             end
      ISSUE: if (!core_busy_i) begin
               core_start_o = 1'b1;
               state_nxt    = WAIT;
             end
      WAIT:  if (core_valid_i || tmo_hit) state_nxt = RESP;
      RESP:  if (rsp_ready_i[gnt_idx]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready is combinational from req_valid_i, so gate it with reset to keep it
  // low while the block is held in reset.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign req_ready_o[i] = rst_n && accept && (pick == IDX_W'(i));
    assign rsp_valid_o[i] = (state == RESP) && (gnt_idx == IDX_W'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last    <= IDX_W'(NUM_REQ - 1);
      gnt_idx <= '0;
      tmo_cnt <= '0;
      result  <= '0;
      err     <= 1'b0;
      mode_q  <= 1'b0;
      data_q  <= '0;
      key_q   <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          gnt_idx <= pick;
          mode_q  <= req_mode_i[pick];
          data_q  <= req_data_v[pick];
          key_q   <= req_key_v[pick];
        end
        ISSUE: if (!core_busy_i) tmo_cnt <= '0;
        WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          // A valid arriving on the timeout cycle still counts as success.
          if (core_valid_i) begin
            result <= core_result_i;
            err    <= 1'b0;
          end else if (tmo_hit) begin
            result <= '0;
            err    <= 1'b1;
          end
        end
        RESP: if (rsp_ready_i[gnt_idx]) begin
          last <= gnt_idx;
          err  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign rsp_data_o  = result;
  assign rsp_err_o   = err;
  assign grant_idx_o = gnt_idx;
  assign core_mode_o = mode_q;
  assign core_data_o = data_q;
  assign core_key_o  = key_q;

endmodule

// File: tb/tb_aes256_req_arbiter.sv
module tb_aes256_req_arbiter;
  localparam int NUM_REQ = 4;
  localparam logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NUM_REQ-1:0]     req_valid_i, req_ready_o, req_mode_i;
  logic [NUM_REQ*128-1:0] req_data_i;
  logic [NUM_REQ*256-1:0] req_key_i;
  logic [NUM_REQ-1:0]     rsp_valid_o, rsp_ready_i;
  logic [127:0]           rsp_data_o;
  logic                   rsp_err_o;
  logic [1:0]             grant_idx_o;
  logic                   core_start_o, core_mode_o;
  logic [127:0]           core_data_o;
  logic [255:0]           core_key_o;
  logic [127:0]           core_result_i;
  logic                   core_valid_i, core_busy_i;

  int total = 0;
  int bad   = 0;

  aes256_req_arbiter #(.NUM_REQ(4), .IDX_W(2), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_mode_i(req_mode_i),
    .req_data_i(req_data_i), .req_key_i(req_key_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o), .grant_idx_o(grant_idx_o),
    .core_start_o(core_start_o), .core_mode_o(core_mode_o),
    .core_data_o(core_data_o), .core_key_o(core_key_o),
    .core_result_i(core_result_i), .core_valid_i(core_valid_i), .core_busy_i(core_busy_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input bit ok);
    total++;
    if (!ok) begin
      bad++;
      $error("FAIL %s", tag);
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic m, input logic [127:0] d, input logic [255:0] k);
    if (k == KEY && d == PT && !m) return CT;
    if (k == KEY && d == CT &&  m) return PT;
    return d ^ k[255:128] ^ k[127:0] ^ {128{m}};
  endfunction

  logic [4:0] ccnt;
  logic       core_en;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccnt          <= '0;
      core_valid_i  <= 1'b0;
      core_result_i <= '0;
    end else begin
      core_valid_i <= 1'b0;
      if (core_start_o) ccnt <= 5'd17;
      else if (ccnt != 0) begin
        ccnt <= ccnt - 1'b1;
        if (ccnt == 1 && core_en) begin
          core_valid_i  <= 1'b1;
          core_result_i <= aes_ref(core_mode_o, core_data_o, core_key_o);
        end
      end
    end
  end

  typedef struct {
    int           idx;
    logic [127:0] data;
    logic         err;
  } exp_t;
  exp_t sb[$];

  logic         m_v [NUM_REQ];
  logic [127:0] d_v [NUM_REQ];
  logic [255:0] k_v [NUM_REQ];
  bit           moved;

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic m, input logic [127:0] d, input logic [255:0] k);
    m_v[r] = m; d_v[r] = d; k_v[r] = k;
    req_mode_i[r] = m;
    req_data_i[r*128 +: 128] = d;
    req_key_i[r*256 +: 256] = k;
  endtask

  task automatic accept(input int r, input bit exp_err);
    bit seen;
    logic [3:0] oh;
    seen = 1'b0;
    oh = 4'(1) << r;
    req_valid_i[r] = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (req_ready_o != 0) begin
        seen = 1'b1;
        break;
      end
      cyc();
    end
    chk("accept_seen", seen === 1'b1);
    chk("ready_onehot", req_ready_o === oh);
    if (seen) sb.push_back('{r, exp_err ? 128'h0 : aes_ref(m_v[r], d_v[r], k_v[r]), exp_err});
    cyc();
    req_valid_i[r] = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output int n);
    logic [255:0] k0;
    logic [127:0] d0;
    logic         m0;
    k0 = core_key_o; d0 = core_data_o; m0 = core_mode_o;
    moved = 1'b0;
    n = 0;
    while (rsp_valid_o == 0 && n < budget) begin
      cyc();
      n++;
      if (core_key_o !== k0 || core_data_o !== d0 || core_mode_o !== m0) moved = 1'b1;
    end
    chk("rsp_arrived", (rsp_valid_o != 0) === 1'b1);
  endtask

  task automatic consume();
    exp_t e;
    logic [3:0] oh;
    chk("sb_nonempty", (sb.size() > 0) === 1'b1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      oh = 4'(1) << e.idx;
      chk("rsp_valid", rsp_valid_o === oh);
      chk("rsp_data", rsp_data_o === e.data);
      chk("rsp_err", rsp_err_o === e.err);
      rsp_ready_i[e.idx] = 1'b1;
      cyc();
      rsp_ready_i[e.idx] = 1'b0;
      chk("rsp_clear", rsp_valid_o === 4'b0);
    end
  endtask

  initial begin
    int   n, nrsp, idx;
    int   order[$];
    int   exp_ord[5];
    exp_t e;
    logic [127:0] hold_d;
    bit   hold_bad, start_early;
    logic [3:0] oh;

    exp_ord = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    req_valid_i = '0; req_mode_i = '0; req_data_i = '0; req_key_i = '0;
    rsp_ready_i = '0; core_busy_i = 1'b0; core_en = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, '0, '0);

    cyc(); cyc();
    chk("rst_ready", req_ready_o === 4'b0);
    chk("rst_rsp_valid", rsp_valid_o === 4'b0);
    chk("rst_grant", grant_idx_o === 2'd0);
    chk("rst_start", core_start_o === 1'b0);
    chk("rst_key", core_key_o === 256'h0);
    chk("rst_err", rsp_err_o === 1'b0);
    rst_n = 1'b1;
    cyc();

    set_req(0, 1'b0, PT, KEY);
    accept(0, 1'b0);
    chk("enc_start", core_start_o === 1'b1);
    wait_rsp(40, n);
    chk("enc_latency", (n + 1) === 20);
    chk("enc_grant", grant_idx_o === 2'd0);
    consume();

    set_req(2, 1'b1, CT, KEY);
    accept(2, 1'b0);
    chk("dec_key", core_key_o === KEY);
    wait_rsp(40, n);
    chk("dec_key_stable", moved === 1'b0);
    consume();

    rst_n = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, PT + 128'(i), KEY ^ 256'(i));
    req_valid_i = '1;
    rsp_ready_i = '1;
    cyc();
    chk("rst_ready_gated", req_ready_o === 4'b0);
    rst_n = 1'b1;
    #1;
    nrsp = 0;
    for (int c = 0; c < 300 && nrsp < 5; c++) begin
      if (req_ready_o != 0) begin
        chk("cont_onehot", $onehot(req_ready_o) === 1'b1);
        idx = 0;
        for (int i = 0; i < NUM_REQ; i++) if (req_ready_o[i]) idx = i;
        order.push_back(idx);
        sb.push_back('{idx, aes_ref(m_v[idx], d_v[idx], k_v[idx]), 1'b0});
      end
      if (rsp_valid_o != 0 && sb.size() > 0) begin
        e = sb.pop_front();
        oh = 4'(1) << e.idx;
        chk("cont_rsp_valid", rsp_valid_o === oh);
        chk("cont_rsp_data", rsp_data_o === e.data);
        nrsp++;
        if (nrsp == 5) req_valid_i = '0;
      end
      cyc();
    end
    rsp_ready_i = '0;
    chk("cont_rsp_count", nrsp === 5);
    chk("cont_grant_count", order.size() === 5);
    for (int i = 0; i < 5 && i < order.size(); i++) chk("cont_order", order[i] === exp_ord[i]);

    set_req(1, 1'b0, 128'hcafe_f00d, KEY);
    set_req(3, 1'b1, 128'h1234_5678, ~KEY);
    req_valid_i[3] = 1'b1;
    rsp_ready_i = 4'b1101;
    accept(1, 1'b0);
    wait_rsp(40, n);
    hold_d = rsp_data_o;
    hold_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (rsp_valid_o !== 4'b0010 || rsp_data_o !== hold_d || req_ready_o !== 4'b0) hold_bad = 1'b1;
    end
    chk("bp_stable", hold_bad === 1'b0);
    rsp_ready_i = '0;
    consume();
    accept(3, 1'b0);
    wait_rsp(40, n);
    consume();

    core_busy_i = 1'b1;
    core_en = 1'b0;
    set_req(2, 1'b0, 128'h5a5a, KEY);
    accept(2, 1'b1);
    start_early = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (core_start_o) start_early = 1'b1;
      cyc();
    end
    chk("busy_no_start", start_early === 1'b0);
    core_busy_i = 1'b0;
    #1;
    chk("busy_start", core_start_o === 1'b1);
    wait_rsp(100, n);
    chk("tmo_wait_cycles", n === 65);
    consume();

    set_req(3, 1'b0, 128'h77, KEY);
    accept(3, 1'b0);
    repeat (8) cyc();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid_o === 4'b0);
    chk("mid_rst_key", core_key_o === 256'h0);
    chk("mid_rst_data", core_data_o === 128'h0);
    chk("mid_rst_grant", grant_idx_o === 2'd0);
    chk("mid_rst_start", core_start_o === 1'b0);
    sb.delete();
    core_en = 1'b1;
    set_req(0, 1'b1, 128'h99, KEY);
    req_valid_i[3] = 1'b1;
    cyc();
    rst_n = 1'b1;
    accept(0, 1'b0);
    req_valid_i[3] = 1'b0;
    wait_rsp(40, n);
    consume();
    chk("sb_drained", sb.size() === 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
